// File: rtl/smc_pkg.sv
// Shared types for the SMC sequential MOSFET Id/gm evaluator:
// operating-region encoding, sequencer states and mode selectors.
package smc_pkg;

  typedef enum logic [1:0] {
    REG_CUTOFF = 2'd0,
    REG_TRIODE = 2'd1,
    REG_SAT    = 2'd2
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam logic MODE_ID = 1'b0;
  localparam logic MODE_GM = 1'b1;

endpackage

// File: rtl/smc_mos_eval.sv
// Combinational square-law evaluator for one channel: Id or gm plus region.
// Zero latency; no flow control (the caller sequences channels through it).
module smc_mos_eval
  import smc_pkg::*;
#(
  parameter int VW = 3,
  parameter int OW = 10
) (
  input  logic [VW-1:0] vgs,
  input  logic [VW-1:0] vds,
  input  logic [VW-1:0] w,
  input  logic          mode,
  output logic [OW-1:0] value,
  output region_e       region
);

  // Two guard bits above 3*VW keep 2*ov*Vds and W*(...) free of overflow.
  localparam int PW = 3 * VW + 2;

  logic [PW-1:0] vgs_x;
  logic [PW-1:0] vds_x;
  logic [PW-1:0] w_x;
  logic [PW-1:0] ov;
  logic [PW-1:0] num;

  always_comb begin
    vgs_x  = PW'(vgs);
    vds_x  = PW'(vds);
    w_x    = PW'(w);
    ov     = vgs_x - PW'(1);
    num    = '0;
    region = REG_CUTOFF;
    if (vgs_x <= PW'(1)) begin
      region = REG_CUTOFF;
    end else if (ov > vds_x) begin
      // ov > Vds guarantees 2*ov*Vds >= Vds^2, so the difference never wraps.
      region = REG_TRIODE;
      num    = (mode == MODE_GM) ? PW'(2) * w_x * vds_x
                                 : w_x * (PW'(2) * ov * vds_x - vds_x * vds_x);
    end else begin
      region = REG_SAT;
      num    = (mode == MODE_GM) ? PW'(2) * w_x * ov
                                 : w_x * ov * ov;
    end
    value = OW'(num / PW'(3));
  end

endmodule

// File: rtl/smc_calc_seq.sv
// Frame sequencer: loads NCH operating points, evaluates one channel per cycle
// on a shared evaluator, then streams tagged results under valid/ready.
module smc_calc_seq
  import smc_pkg::*;
#(
  parameter int NCH = 6,
  parameter int VW  = 3,
  parameter int OW  = 10
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_mode,
  input  logic [VW-1:0]                            in_vgs,
  input  logic [VW-1:0]                            in_vds,
  input  logic [VW-1:0]                            in_w,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OW-1:0]                            out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic [1:0]                               out_region,
  output logic                                     out_last
);

  localparam int            CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  if (OW < 3 * VW) begin : g_ow_check
    $error("smc_calc_seq: OW must be at least 3*VW");
  end
  if (NCH < 1 || NCH > 16) begin : g_nch_check
    $error("smc_calc_seq: NCH must be within 1..16");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          in_ready_q, in_ready_d;

  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  region_e       out_region_q, out_region_d;
  logic          out_last_q, out_last_d;

  logic [VW-1:0] vgs_q [NCH];
  logic [VW-1:0] vds_q [NCH];
  logic [VW-1:0] w_q   [NCH];
  logic [OW-1:0] res_q [NCH];
  region_e       rgn_q [NCH];

  logic          in_acc;
  logic          res_we;
  logic [CW-1:0] nxt_ch;
  logic [OW-1:0] ev_value;
  region_e       ev_region;

  smc_mos_eval #(
    .VW (VW),
    .OW (OW)
  ) u_eval (
    .vgs    (vgs_q[cnt_q]),
    .vds    (vds_q[cnt_q]),
    .w      (w_q[cnt_q]),
    .mode   (mode_q),
    .value  (ev_value),
    .region (ev_region)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_region_d = out_region_q;
    out_last_d   = out_last_q;
    in_acc       = 1'b0;
    res_we       = 1'b0;
    nxt_ch       = out_ch_q + CW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          in_acc = 1'b1;
          mode_d = in_mode;
          if (NCH == 1) begin
            state_d = ST_CALC;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          in_acc = 1'b1;
          if (cnt_q == LAST_CH) begin
            state_d = ST_CALC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_CALC: begin
        res_we = 1'b1;
        if (cnt_q == LAST_CH) begin
          // Channel 0 is already buffered unless it is the one being computed now.
          state_d      = ST_OUT;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_ch_d     = '0;
          out_last_d   = (NCH == 1);
          out_data_d   = (NCH == 1) ? ev_value : res_q[0];
          out_region_d = (NCH == 1) ? ev_region : rgn_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_ch_d     = '0;
            out_region_d = REG_CUTOFF;
            out_last_d   = 1'b0;
          end else begin
            out_ch_d     = nxt_ch;
            out_data_d   = res_q[nxt_ch];
            out_region_d = rgn_q[nxt_ch];
            out_last_d   = (nxt_ch == LAST_CH);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mode_q       <= MODE_ID;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_region_q <= REG_CUTOFF;
      out_last_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        vgs_q[i] <= '0;
        vds_q[i] <= '0;
        w_q[i]   <= '0;
        res_q[i] <= '0;
        rgn_q[i] <= REG_CUTOFF;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_region_q <= out_region_d;
      out_last_q   <= out_last_d;
      if (in_acc) begin
        vgs_q[cnt_q] <= in_vgs;
        vds_q[cnt_q] <= in_vds;
        w_q[cnt_q]   <= in_w;
      end
      if (res_we) begin
        res_q[cnt_q] <= ev_value;
        rgn_q[cnt_q] <= ev_region;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_region = out_region_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_smc_calc_seq.sv
// Bench for smc_calc_seq: hand-computed frame table, reset/backpressure sequences,
// and random frames scored against an arithmetic model of the device equations.
module tb_smc_calc_seq;

  localparam int NCH = 6;
  localparam int VW  = 3;
  localparam int OW  = 10;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [VW-1:0] in_vgs;
  logic [VW-1:0] in_vds;
  logic [VW-1:0] in_w;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic [1:0]    out_region;
  logic          out_last;

  smc_calc_seq #(.NCH(NCH), .VW(VW), .OW(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_vgs     (in_vgs),
    .in_vds     (in_vds),
    .in_w       (in_w),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_region (out_region),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vgs;
    int vds;
    int w;
    bit mode;
    int val;
    int rg;
  } vec_t;

  vec_t tbl [24];

  int n_chk = 0;
  int n_err = 0;

  logic [VW-1:0] fr_vgs [NCH];
  logic [VW-1:0] fr_vds [NCH];
  logic [VW-1:0] fr_w   [NCH];
  int exp_val [NCH];
  int exp_rg  [NCH];
  int got_val [NCH];
  int got_ch  [NCH];
  int got_rg  [NCH];
  int got_last[NCH];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Square-law device model in plain integer arithmetic; region 0/1/2 = cutoff/triode/sat.
  function automatic void model(input int vgs, input int vds, input int w, input bit m,
                                output int val, output int rg);
    int ov;
    ov = vgs - 1;
    if (vgs <= 1) begin
      val = 0;
      rg  = 0;
    end else if (ov > vds) begin
      rg  = 1;
      val = m ? (2 * w * vds) / 3 : (w * (2 * ov * vds - vds * vds)) / 3;
    end else begin
      rg  = 2;
      val = m ? (2 * w * ov) / 3 : (w * ov * ov) / 3;
    end
  endfunction

  task automatic drive_junk();
    in_valid = 1'($urandom_range(0, 1));
    in_mode  = 1'($urandom_range(0, 1));
    in_vgs   = VW'($urandom);
    in_vds   = VW'($urandom);
    in_w     = VW'($urandom);
  endtask

  // Loads load_n beats, then (for a full load) accepts res_n results.
  // bp: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
  task automatic run_frame(input bit m, input int gap, input int bp,
                           input int load_n, input int res_n);
    int cyc;
    int lat;
    int got;
    int bpi;
    bit stall;
    bit stab_ok;
    bit rdy_ok;
    bit rdy;
    logic [OW-1:0] h_dat;
    logic [CW-1:0] h_ch;
    logic [1:0]    h_rg;
    logic          h_last;

    h_dat = '0; h_ch = '0; h_rg = '0; h_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      got_val[i] = -1; got_ch[i] = -1; got_rg[i] = -1; got_last[i] = -1;
    end

    for (int c = 0; c < load_n; c++) begin
      if (c > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_vgs   = fr_vgs[c];
      in_vds   = fr_vds[c];
      in_w     = fr_w[c];
      in_mode  = (c == 0) ? m : ~m;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (!in_ready) begin
        chk("load_ready_timeout", int'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (load_n < NCH) return;

    chk("in_ready_low_after_load", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      drive_junk();
      @(negedge clk);
      lat++;
    end
    chk("first_result_latency", lat, NCH);

    got = 0; cyc = 0; bpi = 0; stall = 1'b0; stab_ok = 1'b1; rdy_ok = 1'b1;
    while (got < res_n && cyc < 400) begin
      if (bp == 0)      rdy = 1'b1;
      else if (bp == 1) rdy = (bpi % 3 == 0);
      else              rdy = 1'($urandom_range(0, 1));
      bpi++;
      if (stall && (out_data !== h_dat || out_ch !== h_ch ||
                    out_region !== h_rg || out_last !== h_last || out_valid !== 1'b1))
        stab_ok = 1'b0;
      if (out_valid) begin
        if (in_ready) rdy_ok = 1'b0;
        if (rdy) begin
          got_val[got]  = int'(out_data);
          got_ch[got]   = int'(out_ch);
          got_rg[got]   = int'(out_region);
          got_last[got] = int'(out_last);
          got++;
        end
        stall  = !rdy;
        h_dat  = out_data;
        h_ch   = out_ch;
        h_rg   = out_region;
        h_last = out_last;
      end else begin
        stall = 1'b0;
      end
      out_ready = rdy;
      if (out_valid && rdy && out_last) in_valid = 1'b0;
      else drive_junk();
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("result_count", got, res_n);
    chk("held_stable_while_stalled", int'(stab_ok), 1);
    chk("in_ready_low_during_out", int'(rdy_ok), 1);
    if (res_n == NCH) begin
      chk("in_ready_after_frame", int'(in_ready), 1);
      chk("out_valid_after_frame", int'(out_valid), 0);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s_ch%0d_index", tag, i), got_ch[i], i);
      chk($sformatf("%s_ch%0d_last", tag, i), got_last[i], (i == NCH - 1) ? 1 : 0);
      chk($sformatf("%s_ch%0d_value", tag, i), got_val[i], exp_val[i]);
      chk($sformatf("%s_ch%0d_region", tag, i), got_rg[i], exp_rg[i]);
    end
  endtask

  task automatic load_tbl(input int f);
    for (int c = 0; c < NCH; c++) begin
      fr_vgs[c]  = VW'(tbl[f * NCH + c].vgs);
      fr_vds[c]  = VW'(tbl[f * NCH + c].vds);
      fr_w[c]    = VW'(tbl[f * NCH + c].w);
      exp_val[c] = tbl[f * NCH + c].val;
      exp_rg[c]  = tbl[f * NCH + c].rg;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_region", int'(out_region), 0);
    chk("rst_out_last", int'(out_last), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    chk("rel_out_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    chk("rel_no_stale_valid", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    in_vgs = '0; in_vds = '0; in_w = '0;

    // Id frame, gm frame, Id boundaries, gm boundaries.
    tbl[0]  = '{5, 6, 7, 1'b0, 37, 2};
    tbl[1]  = '{2, 6, 7, 1'b0,  2, 2};
    tbl[2]  = '{6, 7, 3, 1'b0, 25, 2};
    tbl[3]  = '{4, 2, 1, 1'b0,  2, 1};
    tbl[4]  = '{5, 3, 4, 1'b0, 20, 1};
    tbl[5]  = '{7, 6, 6, 1'b0, 72, 2};
    tbl[6]  = '{5, 6, 7, 1'b1, 18, 2};
    tbl[7]  = '{2, 6, 7, 1'b1,  4, 2};
    tbl[8]  = '{6, 7, 3, 1'b1, 10, 2};
    tbl[9]  = '{4, 2, 1, 1'b1,  1, 1};
    tbl[10] = '{5, 3, 4, 1'b1,  8, 1};
    tbl[11] = '{7, 6, 6, 1'b1, 24, 2};
    tbl[12] = '{1, 3, 7, 1'b0,  0, 0};
    tbl[13] = '{0, 0, 0, 1'b0,  0, 0};
    tbl[14] = '{4, 3, 5, 1'b0, 15, 2};
    tbl[15] = '{7, 7, 7, 1'b0, 84, 2};
    tbl[16] = '{2, 1, 3, 1'b0,  1, 2};
    tbl[17] = '{3, 1, 6, 1'b0,  6, 1};
    tbl[18] = '{7, 7, 7, 1'b1, 28, 2};
    tbl[19] = '{1, 3, 7, 1'b1,  0, 0};
    tbl[20] = '{4, 3, 5, 1'b1, 10, 2};
    tbl[21] = '{0, 7, 7, 1'b1,  0, 0};
    tbl[22] = '{7, 0, 7, 1'b1,  0, 1};
    tbl[23] = '{3, 1, 6, 1'b1,  4, 1};

    repeat (2) @(negedge clk);
    chk("por_in_ready", int'(in_ready), 0);
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_out_data", int'(out_data), 0);
    chk("por_out_ch", int'(out_ch), 0);
    chk("por_out_region", int'(out_region), 0);
    chk("por_out_last", int'(out_last), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("por_rel_in_ready", int'(in_ready), 1);
    chk("por_rel_out_valid", int'(out_valid), 0);

    for (int f = 0; f < 4; f++) begin
      load_tbl(f);
      run_frame(tbl[f * NCH].mode, (f == 1) ? 2 : 0, f % 2, NCH, NCH);
      check_results($sformatf("tbl%0d", f));
    end

    load_tbl(2);
    run_frame(1'b0, 0, 0, 3, 0);
    do_reset();
    load_tbl(0);
    run_frame(1'b0, 0, 0, NCH, NCH);
    check_results("after_load_reset");

    load_tbl(3);
    run_frame(1'b1, 0, 1, NCH, 2);
    do_reset();
    load_tbl(1);
    run_frame(1'b1, 1, 2, NCH, NCH);
    check_results("after_out_reset");

    for (int f = 0; f < 8; f++) begin
      m = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) begin
        fr_vgs[c] = VW'($urandom);
        fr_vds[c] = VW'($urandom);
        fr_w[c]   = VW'($urandom);
        model(int'(fr_vgs[c]), int'(fr_vds[c]), int'(fr_w[c]), m, exp_val[c], exp_rg[c]);
      end
      run_frame(m, $urandom_range(0, 2), $urandom_range(0, 2), NCH, NCH);
      check_results($sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
